mdu_iter_unit: RTL and testbench
================================

// Module: mdu_iter_unit
// PURPOSE
//  Iterative RV32M/RV64M multiply-divide unit that executes the op the controller issues on mdu_op/mdu_valid.
//  Sits beside the ALU in the execute stage and feeds the WBsel=3 writeback path.
//  Implements all eight M ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
//  Valid/ready handshakes on both sides; busy lets the controller stall the PC and fetch.
// PARAMETERS
//  XLEN  32  operand/result width in bits (32 or 64)
//  CNTW  $clog2(XLEN+1)  iteration counter width (derived, not overridden)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, synchronous, active-high
//  in_valid   in   1     op/operands valid (controller's mdu_valid)
//  in_ready   out  1     unit can accept an op
//  op         in   3     instr[14:12] (funct3) encoding of the M op
//  rs1        in   XLEN  operand a / dividend
//  rs2        in   XLEN  operand b / divisor
//  flush      in   1     discard the in-flight op (branch or jump redirect)
//  out_valid  out  1     result valid
//  out_ready  in   1     writeback accepts result
//  result     out  XLEN  result
//  busy       out  1     op accepted and result not yet consumed
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, busy=0, counter=0. in_ready=1 from the first cycle after rst deasserts.
//  FSM states: IDLE, CALC, DONE.
//   IDLE: in_ready=1. On in_valid&&in_ready, latch op, |rs1|, |rs2|, and the sign flags, then:
//    - fast path -> DONE:
//      - divide op with rs2==0
//      - DIV/REM with rs1=MIN_INT and rs2=-1
//    - all other ops -> CALC with counter=XLEN.
//   CALC: one radix-2 step per cycle.
//    - MUL*: shift-add into a 2*XLEN accumulator.
//    - DIV*/REM*: restoring shift-subtract.
//    - counter decrements each step; when it reaches 1 the next state is DONE. Sign fixup is done on the DONE-entry edge.
//   DONE: out_valid=1 and result held stable until out_ready. On out_valid&&out_ready -> IDLE.
//  Latency: out_valid rises on the (XLEN+1)th rising edge after the accepting edge (33 for XLEN=32); fast path on the next edge.
//  Throughput: one op per XLEN+2 cycles. in_ready=0 in CALC and DONE (no accept in the same cycle as the result handshake).
//  busy = (state != IDLE).
//  Signed rules:
//   - MUL: low XLEN bits of the product.
//   - MULH: rs1 and rs2 signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned. The high XLEN bits of the
//     unsigned magnitude product are taken after negating the 2*XLEN product when the effective signs differ.
//   - DIV: quotient sign = sign(rs1)^sign(rs2). REM: remainder sign = sign(rs1). DIVU/REMU: no fixup.
//  Corner cases (RISC-V spec values):
//   - x/0: DIV/DIVU return all-ones; REM/REMU return rs1.
//   - MIN_INT/-1: DIV returns MIN_INT; REM returns 0.
//  Undefined op (funct3 outside the 8 codes): cannot occur, since all 3-bit codes map to M ops.
//  flush: in CALC or DONE, go to IDLE on the next edge with out_valid=0. A result pending in DONE is dropped.
//   flush in the same cycle as in_valid in IDLE: the op is not accepted. flush outranks out_ready.
//  rst mid-op: the op is abandoned and all outputs return to reset values on that edge.
//  Operand inputs are sampled only at accept; later changes to rs1/rs2/op have no effect.
// STRUCTURE
//  Shared package rv_pkg:
//   - MDU op localparams (MUL=3'b000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111),
//     also used by the controller.
//   - FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2).
//  Single module. A shared 2*XLEN accumulator/remainder register serves both mul and div. No sub-module.
// TESTING (XLEN=32)
//  1 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 33 edges after accept; busy high throughout.
//  2 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  3 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each with out_valid 1 edge after accept.
//  5 flush pulsed 10 cycles into CALC -> out_valid never rises, in_ready=1 next cycle; following MUL 3*4 -> 12 correct.
//  6 out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, in_ready=0; rst pulse mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32M/RV64M definitions: M-extension funct3 codes and the MDU FSM encoding.
package rv_pkg;

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_unit.sv
// Iterative radix-2 multiply/divide unit for the M extension. Operands are reduced to magnitudes
// at accept, one shift-add / shift-subtract step runs per cycle, and signs are fixed on DONE entry.
module mdu_iter_unit
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNTW = $clog2(XLEN + 1);

  mdu_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              out_valid_q, out_valid_d;

  logic              rs1_signed, rs2_signed, s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0]   abs1, abs2, fast_res;
  logic [XLEN:0]     mul_sum, div_top, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    rs1_signed = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    rs2_signed = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    s1         = rs1_signed & rs1[XLEN-1];
    s2         = rs2_signed & rs2[XLEN-1];
    abs1       = s1 ? -rs1 : rs1;
    abs2       = s2 ? -rs2 : rs2;
    div_zero   = op[2] && (rs2 == '0);
    div_ovf    = ((op == OpDiv) || (op == OpRem)) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (rs2 == '1);
    // REM/REMU have op[1] set: x/0 yields rs1, MIN/-1 yields 0; quotients yield ones / MIN.
    if (div_zero) fast_res = op[1] ? rs1 : '1;
    else          fast_res = op[1] ? '0 : rs1;
  end

  // Multiply shifts the product right through the multiplier; divide shifts the
  // remainder:quotient pair left, keeping the subtraction only when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_top - {1'b0, opb_q};
    div_next = {div_diff[XLEN] ? div_top[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0],
                ~div_diff[XLEN]};
    step     = op_q[2] ? div_next : mul_next;
    prod_fix = neg_q ? -step : step;
    quo      = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem      = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    if (op_q[2])            final_res = op_q[1] ? rem : quo;
    else if (op_q == OpMul) final_res = prod_fix[XLEN-1:0];
    else                    final_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    neg_d       = neg_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !flush) begin
          op_d  = op;
          neg_d = op[1] && op[2] ? s1 : (s1 ^ s2);
          if (div_zero || div_ovf) begin
            result_d    = fast_res;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs1};
            opb_d   = abs2;
            cnt_d   = CNTW'(XLEN);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            result_d    = final_res;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        if (flush || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= OpMul;
      cnt_q       <= '0;
      acc_q       <= '0;
      opb_q       <= '0;
      neg_q       <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      neg_q       <= neg_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Scoreboard bench for mdu_iter_unit (XLEN=32): expected results queued at issue, popped at out_valid.
module tb_mdu_iter_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MinInt = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            flush = 1'b0;
  logic            out_ready = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            in_ready, out_valid, busy;
  logic [XLEN-1:0] result;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mdu_iter_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'b000: begin up = ua * ub; return up[31:0]; end
      3'b001: begin sp = sa * sb; return sp[63:32]; end
      3'b010: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MinInt && b == 32'hFFFF_FFFF) return MinInt;
        sp = sa / sb; return sp[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MinInt && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  // Caller sits 1 time unit after an edge with the DUT idle; returns 1 unit after the accepting edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
  endtask

  // n counts edges with the accepting edge as 1; n = -1 on timeout.
  task automatic wait_valid(output int n, output bit busy_ok);
    n = 1;
    busy_ok = busy;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL reset_flags got %b want 001",
                                                         {out_valid, busy, in_ready});
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result);
    else pass_cnt++;
  endtask

  task automatic test_mul_latency();
    int n; bit bok; logic [31:0] e;
    exp_q.push_back(32'hFFFF_FFEB);
    start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_valid(n, bok);
    e = exp_q.pop_front();
    total_cnt++;
    if (result !== e) $display("FAIL mul_result got %h want %h", result, e); else pass_cnt++;
    total_cnt++;
    if (n !== 33) $display("FAIL mul_latency got %0d want 33", n); else pass_cnt++;
    total_cnt++;
    if (bok !== 1'b1) $display("FAIL mul_busy got %b want 1", bok); else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL done_in_ready got %b want 0", in_ready); else pass_cnt++;
    consume();
    total_cnt++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      $display("FAIL mul_after_hs got %b want 001", {out_valid, busy, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_mulh();
    logic [2:0]  ops[3] = '{3'b001, 3'b011, 3'b010};
    logic [31:0] av[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev[3]  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int n; bit bok; logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev[i]);
      start_op(ops[i], av[i], bv[i]);
      wait_valid(n, bok);
      e = exp_q.pop_front();
      total_cnt++;
      if (result !== e || n !== 33)
        $display("FAIL mulh_op%0d got %h lat %0d want %h lat 33", ops[i], result, n, e);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av[4]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] bv[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ev[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int n; bit bok; logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev[i]);
      start_op(ops[i], av[i], bv[i]);
      wait_valid(n, bok);
      e = exp_q.pop_front();
      total_cnt++;
      if (result !== e || n !== 33)
        $display("FAIL div_op%0d got %h lat %0d want %h lat 33", ops[i], result, n, e);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  ops[4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] av[4]  = '{32'd5, 32'd5, MinInt, MinInt};
    logic [31:0] bv[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev[4]  = '{32'hFFFF_FFFF, 32'd5, MinInt, 32'd0};
    int n; bit bok; logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev[i]);
      start_op(ops[i], av[i], bv[i]);
      wait_valid(n, bok);
      e = exp_q.pop_front();
      total_cnt++;
      if (result !== e) $display("FAIL fast_op%0d_result got %h want %h", ops[i], result, e);
      else pass_cnt++;
      total_cnt++;
      if (n !== 1) $display("FAIL fast_op%0d_latency got %0d want 1", ops[i], n);
      else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_flush();
    int rises; int n; bit bok; logic [31:0] e;
    start_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total_cnt++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      $display("FAIL flush_calc got %b want 001", {out_valid, busy, in_ready});
    else pass_cnt++;
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) rises++;
    end
    total_cnt++;
    if (rises !== 0) $display("FAIL flush_no_result got %0d want 0", rises); else pass_cnt++;
    in_valid = 1'b1; flush = 1'b1; op = 3'b000;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL flush_blocks_accept got %b want 0", busy); else pass_cnt++;
    start_op(3'b101, 32'd5, 32'd0);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flush = 1'b0;
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL flush_done got %b want 01", {out_valid, in_ready});
    else pass_cnt++;
    exp_q.push_back(32'd12);
    start_op(3'b000, 32'd3, 32'd4);
    wait_valid(n, bok);
    e = exp_q.pop_front();
    total_cnt++;
    if (result !== e || n !== 33)
      $display("FAIL flush_then_mul got %h lat %0d want %h lat 33", result, n, e);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_stall_and_reset();
    int n; bit bok; int bad; logic [31:0] e, first;
    exp_q.push_back(32'd14);
    start_op(3'b101, 32'd100, 32'd7);
    wait_valid(n, bok);
    first = result;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (result !== first || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL stall_hold got %0d bad cycles want 0", bad); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (result !== e) $display("FAIL stall_result got %h want %h", result, e); else pass_cnt++;
    consume();
    start_op(3'b000, 32'h0000_1234, 32'h0000_5678);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if ({out_valid, busy, in_ready} !== 3'b001)
      $display("FAIL rst_mid_flags got %b want 001", {out_valid, busy, in_ready});
    else pass_cnt++;
    total_cnt++;
    if (result !== 32'h0) $display("FAIL rst_mid_result got %h want 00000000", result);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n; bit bok; logic [31:0] e, a, b; logic [2:0] o; int want_lat;
    for (int i = 0; i < 10; i++) begin
      o = 3'(i % 8);
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : $urandom;
      if (i == 6) begin a = MinInt; b = 32'hFFFF_FFFF; o = 3'b110; end
      if (i == 9) begin a = MinInt; b = 32'hFFFF_FFFF; o = 3'b001; end
      want_lat = (o[2] && (b == 0 || (!o[0] && a == MinInt && b == 32'hFFFF_FFFF))) ? 1 : 33;
      exp_q.push_back(ref_mdu(o, a, b));
      start_op(o, a, b);
      wait_valid(n, bok);
      e = exp_q.pop_front();
      total_cnt++;
      if (result !== e || n !== want_lat)
        $display("FAIL b2b_%0d op%0d a=%h b=%h got %h lat %0d want %h lat %0d",
                 i, o, a, b, result, n, e, want_lat);
      else pass_cnt++;
      consume();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_mul_latency();
    test_mulh();
    test_div();
    test_fast_path();
    test_flush();
    test_stall_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
